// File: rtl/adc_sequencer.sv
// adc_sequencer: free-running round-robin scan engine for an 8-channel 12-bit
// serial ADC (CS_N / SADDR / SCLK / SDAT). It keeps a latest-value bank and
// emits a one-clock strobe for every stored sample.
// Each frame returns the conversion of the address sent in the previous frame,
// so the first frame after leaving IDLE carries nothing useful and is dropped.
module adc_sequencer #(
  parameter int CLK_DIV = 16,
  parameter int NUM_CH  = 8,
  parameter int GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_saddr,
  output logic        adc_sclk,
  input  logic        adc_sdat,
  input  logic [2:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic [11:0] sample_data,
  output logic        sweep_done
);

  localparam int CNT_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  div_cnt;
  logic              half_tick, gap_tick;
  logic              ph;            // 0 = sclk low half, 1 = sclk high half
  logic [3:0]        bit_idx;
  logic [2:0]        next_ch, cur_ch;
  logic              discard;
  logic              sdat_s1, sdat_s2;
  logic              cap_req;
  logic [1:0]        vld_pipe;      // capture strobe delayed to match the synchroniser
  logic [11:0]       shift_reg, shift_fin;
  logic              gap_entry;
  logic [7:0][11:0]  bank;

  assign half_tick = (div_cnt == CNT_W'(CLK_DIV - 1));
  assign gap_tick  = (div_cnt == CNT_W'(GAP_CYC - 1));
  assign gap_entry = (state == SHIFT) && (state_nxt == GAP);

  // Rising-edge tick of a data cycle (b >= 4); the leading zeros are skipped.
  assign cap_req = (state == SHIFT) && !ph && half_tick && (bit_idx >= 4'd4);

  // With CLK_DIV=2 the last capture lands on the GAP-entry edge; fold it in.
  assign shift_fin = vld_pipe[1] ? {shift_reg[10:0], sdat_s2} : shift_reg;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; enable is only looked at in IDLE and at the end of GAP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = START;
      START:   if (half_tick) state_nxt = SHIFT;
      SHIFT:   if (half_tick && ph && (bit_idx == 4'd15)) state_nxt = GAP;
      GAP:     if (gap_tick) state_nxt = enable ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin decode: idle levels everywhere except START/SHIFT.
  always_comb begin
    adc_cs_n  = 1'b1;
    adc_sclk  = 1'b1;
    adc_saddr = 1'b0;
    case (state)
      START: adc_cs_n = 1'b0;
      SHIFT: begin
        adc_cs_n = 1'b0;
        adc_sclk = ph;
        case (bit_idx)
          4'd2:    adc_saddr = next_ch[2];
          4'd3:    adc_saddr = next_ch[1];
          4'd4:    adc_saddr = next_ch[0];
          default: adc_saddr = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  // Half-period / gap counter; restarts on every state entry and on wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                div_cnt <= '0;
    else if (state_nxt != state || state == IDLE) div_cnt <= '0;
    else if (state != GAP && half_tick)          div_cnt <= '0;
    else                                         div_cnt <= div_cnt + 1'b1;
  end

  // SCLK phase and bit index; b advances on each falling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph      <= 1'b0;
      bit_idx <= '0;
    end else if (state != SHIFT) begin
      ph      <= 1'b0;
      bit_idx <= '0;
    end else if (half_tick) begin
      ph <= ~ph;
      if (ph) bit_idx <= bit_idx + 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous DOUT pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sdat_s1 <= 1'b0;
      sdat_s2 <= 1'b0;
    end else begin
      sdat_s1 <= adc_sdat;
      sdat_s2 <= sdat_s1;
    end
  end

  // Capture two clocks after the rising tick, MSB first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      shift_reg <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], cap_req};
      if (vld_pipe[1]) shift_reg <= {shift_reg[10:0], sdat_s2};
    end
  end

  // Channel bookkeeping: next_ch is addressed now, cur_ch owns the returning data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_ch <= '0;
      cur_ch  <= '0;
      discard <= 1'b1;
    end else if (state == IDLE && enable) begin
      next_ch <= '0;
      discard <= 1'b1;
    end else if (gap_entry) begin
      cur_ch  <= next_ch;
      next_ch <= (next_ch == LAST_CH) ? 3'd0 : next_ch + 3'd1;
      discard <= 1'b0;
    end
  end

  // Bank write and sample strobes at GAP entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank         <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      sweep_done   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      sweep_done   <= 1'b0;
      if (gap_entry && !discard) begin
        bank[cur_ch] <= shift_fin;
        sample_valid <= 1'b1;
        sample_ch    <= cur_ch;
        sample_data  <= shift_fin;
        sweep_done   <= (cur_ch == LAST_CH);
      end
    end
  end

  assign rd_data = (int'(rd_addr) < NUM_CH) ? bank[rd_addr] : 12'd0;

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: a default build (u_dut in mdl[0]) and a
// NUM_CH=3 / CLK_DIV=2 / GAP_CYC=1 build (mdl[1]), each attached to a
// behavioural ADC that answers with the value table for the previously sent address.
module tb_adc_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #10 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : mdl
    logic        en = 1'b0;
    logic        sdat = 1'b0;
    logic [2:0]  rd_addr = 3'd0;
    logic        cs_n, sclk, saddr, sv, sdone;
    logic [2:0]  sch;
    logic [11:0] rd_data, sdata;
    logic [11:0] val [8];
    int frames = 0, frame_len = 0, gap_len = 0, per_min = 1000, per_max = 0;
    int rise_n = 0, fall_n = 0, clk_cnt = 0, last_rise = 0, last_fs = 0, cs_hi = 0;
    logic        p_cs = 1'b1, p_sclk = 1'b1;
    logic [2:0]  addr = 3'd0, pending = 3'd0;
    logic [11:0] word = 12'd0;
    logic [15:0] sa_word = 16'd0;
    logic [15:0] sa_q [$];
    int          st_ch [$];
    int          st_frame [$];
    logic [11:0] st_data [$];
    logic        st_done [$];

    adc_sequencer #(
      .CLK_DIV((g == 0) ? 16 : 2),
      .NUM_CH ((g == 0) ? 8 : 3),
      .GAP_CYC((g == 0) ? 4 : 1)
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .enable(en),
      .adc_cs_n(cs_n), .adc_saddr(saddr), .adc_sclk(sclk), .adc_sdat(sdat),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .sample_valid(sv), .sample_ch(sch), .sample_data(sdata), .sweep_done(sdone)
    );

    // ADC model and pin/strobe monitor, sampled 1 time unit after each edge.
    always @(posedge clk) begin
      #1;
      clk_cnt++;
      if (cs_n) begin
        cs_hi++;
        rise_n = 0;
        fall_n = 0;
      end
      if (p_cs && !cs_n) begin
        frames++;
        gap_len   = cs_hi;
        frame_len = clk_cnt - last_fs;
        last_fs   = clk_cnt;
        cs_hi     = 0;
        word      = val[pending];
        sa_word   = 16'd0;
        sdat      = 1'b0;
      end
      if (!cs_n && p_sclk && !sclk && fall_n < 16) begin
        if (fall_n < 4) sdat = 1'b0;
        else            sdat = word[4'(15 - fall_n)];
        sa_word[fall_n] = saddr;
        fall_n++;
      end
      if (!cs_n && !p_sclk && sclk) begin
        if (rise_n > 0) begin
          if (clk_cnt - last_rise < per_min) per_min = clk_cnt - last_rise;
          if (clk_cnt - last_rise > per_max) per_max = clk_cnt - last_rise;
        end
        last_rise = clk_cnt;
        if (rise_n >= 2 && rise_n <= 4) addr = {addr[1:0], saddr};
        rise_n++;
        if (rise_n == 16) begin
          pending = addr;
          sa_q.push_back(sa_word);
        end
      end
      if (sv) begin
        st_ch.push_back(int'(sch));
        st_data.push_back(sdata);
        st_done.push_back(sdone);
        st_frame.push_back(frames);
      end
      p_cs   = cs_n;
      p_sclk = sclk;
    end
  end

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2000) @(posedge clk);
    #2;
    n_tests++; if (mdl[0].cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n got %b want 1", mdl[0].cs_n); end
    n_tests++; if (mdl[0].sclk !== 1'b1) begin n_fail++; $display("FAIL reset_sclk got %b want 1", mdl[0].sclk); end
    n_tests++; if (mdl[0].saddr !== 1'b0) begin n_fail++; $display("FAIL reset_saddr got %b want 0", mdl[0].saddr); end
    n_tests++; if (mdl[0].st_ch.size() != 0) begin n_fail++; $display("FAIL reset_no_strobe got %0d want 0", mdl[0].st_ch.size()); end
    n_tests++; if (mdl[0].sch !== 3'd0 || mdl[0].sdata !== 12'd0 || mdl[0].sdone !== 1'b0) begin
      n_fail++; $display("FAIL reset_sample_out got ch=%0d data=%h done=%b want 0", mdl[0].sch, mdl[0].sdata, mdl[0].sdone);
    end
    for (int a = 0; a < 8; a++) begin
      mdl[0].rd_addr = 3'(a);
      #1;
      n_tests++; if (mdl[0].rd_data !== 12'd0) begin n_fail++; $display("FAIL reset_bank[%0d] got %h want 000", a, mdl[0].rd_data); end
    end
  endtask

  task automatic test_sweep;
    int f0, s0, q0, n;
    logic [2:0]  a;
    logic [15:0] w;
    for (int i = 0; i < 8; i++) mdl[0].val[i] = 12'hA00 + 12'(i);
    f0 = mdl[0].frames; s0 = mdl[0].st_ch.size(); q0 = mdl[0].sa_q.size();
    mdl[0].per_min = 1000; mdl[0].per_max = 0;
    mdl[0].en = 1'b1;
    n = 0;
    while (mdl[0].st_ch.size() < s0 + 8 && n < 6000) begin @(posedge clk); #2; n++; end
    n_tests++;
    if (mdl[0].st_ch.size() < s0 + 8) begin
      n_fail++; $display("FAIL sweep_timeout got %0d strobes want 8", mdl[0].st_ch.size() - s0);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_tests++; if (mdl[0].st_ch[s0+i] != i) begin n_fail++; $display("FAIL sweep_ch[%0d] got %0d want %0d", i, mdl[0].st_ch[s0+i], i); end
        n_tests++; if (mdl[0].st_data[s0+i] !== mdl[0].val[i]) begin n_fail++; $display("FAIL sweep_data[%0d] got %h want %h", i, mdl[0].st_data[s0+i], mdl[0].val[i]); end
        n_tests++; if (mdl[0].st_done[s0+i] !== (i == 7)) begin n_fail++; $display("FAIL sweep_done[%0d] got %b want %b", i, mdl[0].st_done[s0+i], i == 7); end
        n_tests++; if (mdl[0].st_frame[s0+i] != f0 + 2 + i) begin n_fail++; $display("FAIL sweep_frame[%0d] got %0d want %0d", i, mdl[0].st_frame[s0+i] - f0, 2 + i); end
      end
    end
    mdl[0].rd_addr = 3'd3;
    #1;
    n_tests++; if (mdl[0].rd_data !== 12'hA03) begin n_fail++; $display("FAIL bank3 got %h want a03", mdl[0].rd_data); end
    n_tests++;
    if (mdl[0].sa_q.size() < q0 + 9) begin
      n_fail++; $display("FAIL saddr_frames got %0d want 9", mdl[0].sa_q.size() - q0);
    end else begin
      for (int k = 0; k < 9; k++) begin
        a = 3'(k % 8);
        w = 16'd0; w[2] = a[2]; w[3] = a[1]; w[4] = a[0];
        n_tests++; if (mdl[0].sa_q[q0+k] !== w) begin n_fail++; $display("FAIL saddr_frame%0d got %h want %h", k, mdl[0].sa_q[q0+k], w); end
      end
    end
    n_tests++; if (mdl[0].per_min != 32 || mdl[0].per_max != 32) begin n_fail++; $display("FAIL sclk_period got %0d..%0d want 32", mdl[0].per_min, mdl[0].per_max); end
    n_tests++; if (mdl[0].gap_len != 4) begin n_fail++; $display("FAIL cs_gap got %0d want 4", mdl[0].gap_len); end
    n_tests++; if (mdl[0].frame_len != 532) begin n_fail++; $display("FAIL frame_len got %0d want 532", mdl[0].frame_len); end
  endtask

  task automatic test_enable_drop;
    int n, s0, f0, exp_ch;
    n = 0;
    while (mdl[0].rise_n != 8 && n < 2000) begin @(posedge clk); #2; n++; end
    n_tests++; if (mdl[0].rise_n != 8) begin n_fail++; $display("FAIL drop_wait_b8 got %0d want 8", mdl[0].rise_n); end
    s0 = mdl[0].st_ch.size();
    exp_ch = (s0 > 0) ? (mdl[0].st_ch[s0-1] + 1) % 8 : 0;
    mdl[0].en = 1'b0;
    repeat (1500) @(posedge clk);
    #2;
    n_tests++;
    if (mdl[0].st_ch.size() != s0 + 1) begin
      n_fail++; $display("FAIL drop_strobes got %0d want 1", mdl[0].st_ch.size() - s0);
    end else begin
      n_tests++; if (mdl[0].st_ch[s0] != exp_ch) begin n_fail++; $display("FAIL drop_ch got %0d want %0d", mdl[0].st_ch[s0], exp_ch); end
      n_tests++; if (mdl[0].st_data[s0] !== mdl[0].val[exp_ch]) begin n_fail++; $display("FAIL drop_data got %h want %h", mdl[0].st_data[s0], mdl[0].val[exp_ch]); end
    end
    f0 = mdl[0].frames;
    repeat (600) @(posedge clk);
    #2;
    n_tests++; if (mdl[0].frames != f0 || mdl[0].cs_n !== 1'b1) begin n_fail++; $display("FAIL drop_idle got frames+%0d cs_n=%b want 0,1", mdl[0].frames - f0, mdl[0].cs_n); end
    for (int i = 0; i < 8; i++) mdl[0].val[i] = 12'($urandom);
    f0 = mdl[0].frames; s0 = mdl[0].st_ch.size();
    mdl[0].en = 1'b1;
    n = 0;
    while (mdl[0].st_ch.size() < s0 + 2 && n < 2500) begin @(posedge clk); #2; n++; end
    n_tests++;
    if (mdl[0].st_ch.size() < s0 + 2) begin
      n_fail++; $display("FAIL reen_timeout got %0d strobes want 2", mdl[0].st_ch.size() - s0);
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++; if (mdl[0].st_ch[s0+i] != i) begin n_fail++; $display("FAIL reen_ch[%0d] got %0d want %0d", i, mdl[0].st_ch[s0+i], i); end
        n_tests++; if (mdl[0].st_data[s0+i] !== mdl[0].val[i]) begin n_fail++; $display("FAIL reen_data[%0d] got %h want %h", i, mdl[0].st_data[s0+i], mdl[0].val[i]); end
      end
      n_tests++; if (mdl[0].st_frame[s0] != f0 + 2) begin n_fail++; $display("FAIL reen_discard got frame %0d want 2", mdl[0].st_frame[s0] - f0); end
    end
  endtask

  task automatic test_reset_mid;
    int n, s0, f0;
    n = 0;
    while (mdl[0].rise_n != 10 && n < 2000) begin @(posedge clk); #2; n++; end
    n_tests++; if (mdl[0].rise_n != 10) begin n_fail++; $display("FAIL rst_wait_b10 got %0d want 10", mdl[0].rise_n); end
    s0 = mdl[0].st_ch.size();
    reset_n = 1'b0;
    #1;
    n_tests++; if (mdl[0].cs_n !== 1'b1 || mdl[0].sclk !== 1'b1) begin n_fail++; $display("FAIL rst_pins got cs_n=%b sclk=%b want 1,1", mdl[0].cs_n, mdl[0].sclk); end
    n_tests++; if (mdl[0].sv !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", mdl[0].sv); end
    for (int a = 0; a < 8; a++) begin
      mdl[0].rd_addr = 3'(a);
      #1;
      n_tests++; if (mdl[0].rd_data !== 12'd0) begin n_fail++; $display("FAIL rst_bank[%0d] got %h want 000", a, mdl[0].rd_data); end
    end
    repeat (4) @(posedge clk);
    #2;
    n_tests++; if (mdl[0].st_ch.size() != s0) begin n_fail++; $display("FAIL rst_no_strobe got %0d want 0", mdl[0].st_ch.size() - s0); end
    f0 = mdl[0].frames;
    reset_n = 1'b1;
    n = 0;
    while (mdl[0].st_ch.size() < s0 + 1 && n < 2000) begin @(posedge clk); #2; n++; end
    n_tests++;
    if (mdl[0].st_ch.size() < s0 + 1) begin
      n_fail++; $display("FAIL rst_restart_timeout got 0 strobes want 1");
    end else begin
      n_tests++; if (mdl[0].st_ch[s0] != 0) begin n_fail++; $display("FAIL rst_restart_ch got %0d want 0", mdl[0].st_ch[s0]); end
      n_tests++; if (mdl[0].st_frame[s0] != f0 + 2) begin n_fail++; $display("FAIL rst_restart_discard got frame %0d want 2", mdl[0].st_frame[s0] - f0); end
      n_tests++; if (mdl[0].st_data[s0] !== mdl[0].val[0]) begin n_fail++; $display("FAIL rst_restart_data got %h want %h", mdl[0].st_data[s0], mdl[0].val[0]); end
    end
  endtask

  task automatic test_nch3;
    int n, s0, f0;
    mdl[0].en = 1'b0;
    for (int i = 0; i < 8; i++) mdl[1].val[i] = 12'($urandom);
    f0 = mdl[1].frames; s0 = mdl[1].st_ch.size();
    mdl[1].per_min = 1000; mdl[1].per_max = 0;
    mdl[1].en = 1'b1;
    n = 0;
    while (mdl[1].st_ch.size() < s0 + 7 && n < 3000) begin @(posedge clk); #2; n++; end
    n_tests++;
    if (mdl[1].st_ch.size() < s0 + 7) begin
      n_fail++; $display("FAIL n3_timeout got %0d strobes want 7", mdl[1].st_ch.size() - s0);
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_tests++; if (mdl[1].st_ch[s0+i] != i % 3) begin n_fail++; $display("FAIL n3_ch[%0d] got %0d want %0d", i, mdl[1].st_ch[s0+i], i % 3); end
        n_tests++; if (mdl[1].st_data[s0+i] !== mdl[1].val[i % 3]) begin n_fail++; $display("FAIL n3_data[%0d] got %h want %h", i, mdl[1].st_data[s0+i], mdl[1].val[i % 3]); end
        n_tests++; if (mdl[1].st_done[s0+i] !== (i % 3 == 2)) begin n_fail++; $display("FAIL n3_done[%0d] got %b want %b", i, mdl[1].st_done[s0+i], i % 3 == 2); end
      end
      n_tests++; if (mdl[1].st_frame[s0] != f0 + 2) begin n_fail++; $display("FAIL n3_discard got frame %0d want 2", mdl[1].st_frame[s0] - f0); end
    end
    mdl[1].rd_addr = 3'd5;
    #1;
    n_tests++; if (mdl[1].rd_data !== 12'd0) begin n_fail++; $display("FAIL n3_rd5 got %h want 000", mdl[1].rd_data); end
    mdl[1].rd_addr = 3'd2;
    #1;
    n_tests++; if (mdl[1].rd_data !== mdl[1].val[2]) begin n_fail++; $display("FAIL n3_rd2 got %h want %h", mdl[1].rd_data, mdl[1].val[2]); end
    n_tests++; if (mdl[1].per_min != 4 || mdl[1].per_max != 4) begin n_fail++; $display("FAIL n3_period got %0d..%0d want 4", mdl[1].per_min, mdl[1].per_max); end
    n_tests++; if (mdl[1].gap_len != 1) begin n_fail++; $display("FAIL n3_gap got %0d want 1", mdl[1].gap_len); end
    n_tests++; if (mdl[1].frame_len != 67) begin n_fail++; $display("FAIL n3_frame_len got %0d want 67", mdl[1].frame_len); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mdl[0].val[i] = 12'd0;
      mdl[1].val[i] = 12'd0;
    end
    test_reset();
    test_sweep();
    test_enable_drop();
    test_reset_mid();
    test_nch3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Autonomous scan engine for the on-board 8-channel, 12-bit serial ADC (ADC128S022-style: CS_N, SADDR, SCLK, SDAT).
- Sits directly upstream of the IMU controller. It drives the ADC pins, sweeps channels round-robin, and keeps a latest-value register bank.
- The IMU controller reads the bank by channel address and uses the per-sample strobe for filtering.

Parameters:
- CLK_DIV, 16, system clocks per SCLK half-period (50 MHz / 32 = 1.5625 MHz SCLK); legal range 2..255.
- NUM_CH, 8, channels swept 0..NUM_CH-1; legal range 1..8.
- GAP_CYC, 4, system clocks CS_N held high between frames; minimum 1.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = run continuous sweeps.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_saddr  out  1  ADC serial address (DIN).
- adc_sclk  out  1  ADC serial clock; idles high.
- adc_sdat  in  1  ADC serial data (DOUT); asynchronous input.
- rd_addr  in  3  register bank read channel.
- rd_data  out  12  bank[rd_addr], combinational read.
- sample_valid  out  1  one-clock strobe per stored sample.
- sample_ch  out  3  channel of the current strobe.
- sample_data  out  12  value of the current strobe.
- sweep_done  out  1  one-clock strobe when channel NUM_CH-1 is stored.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=1, adc_saddr=0, sample_valid=0, sweep_done=0, sample_ch=0, sample_data=0, all bank entries=0, state=IDLE, discard flag=1.
- Reset is asynchronous and may occur mid-frame. It returns all outputs to their reset values immediately; no partial sample is stored.
- Clock divider: counter runs 0..CLK_DIV-1 and only in START/SHIFT/GAP. Its terminal count is a half-period tick. The counter clears on state entry.
- IDLE: all pins at idle levels. When enable=1, go to START, set next_ch=0 and discard=1.
- START: adc_cs_n=0, sclk high for one half-period (CS-to-SCLK setup), then SHIFT.
- SHIFT: 16 SCLK cycles, bit index b=0..15. Each cycle is sclk low for one half-period, then high for one half-period.
- DIN: on each falling edge, adc_saddr = address bit for cycle b. The address is next_ch. b=2,3,4 carry bits [2],[1],[0]; all other cycles drive 0.
- DOUT: adc_sdat passes through a 2-flop synchroniser. Sample it on the system clock at the tick that raises sclk, compensating for the 2-cycle synchroniser delay (capture at tick plus 2 clocks).
- Capture rules: b=0..3 are leading zeros and are ignored. b=4..15 shift into a 12-bit register, MSB first.
- After the 16th rising edge, go to GAP. adc_cs_n=1 and sclk=1 for GAP_CYC clocks.
- At GAP entry (one cycle), if discard=0:
  - write bank[cur_ch] = shift value;
  - pulse sample_valid with sample_ch=cur_ch and sample_data=value;
  - pulse sweep_done if cur_ch==NUM_CH-1.
- Also at GAP entry: cur_ch <= next_ch; next_ch <= (next_ch==NUM_CH-1) ? 0 : next_ch+1; discard <= 0.
- Each frame's result belongs to the address sent in the previous frame. Consequently, the first frame after leaving IDLE is always discarded.
- GAP end: if enable=1, go to START; otherwise go to IDLE. enable is sampled only here, so a deassertion mid-frame completes the frame and its store.
- Wrap-around: with NUM_CH=1, every frame addresses channel 0.
- Read port: rd_data = bank[rd_addr]. A read of rd_addr >= NUM_CH returns 0.
- A write and a read of the same entry in the same cycle returns the old value; the new value appears next cycle.
- Frame length: 2*CLK_DIV*(16+0.5) + GAP_CYC clocks = 532 clocks at defaults.

Test Plan:
- Reset, enable=0, 2000 clocks -> adc_cs_n=1, adc_sclk=1, no sample_valid pulses, rd_data=0 for all addresses.
- enable=1; ADC model returns 0xA00+addr for each channel -> first frame gives no strobe. Subsequent strobes run ch0..ch7 with data 0xA00..0xA07, then sweep_done. bank[3] reads 0xA03.
- Check SADDR waveform during the frame addressing ch5 -> bits 1,0,1 on falling edges b=2..4, 0 elsewhere. Check SCLK period = 32 clocks and CS_N gap = 4 clocks.
- Deassert enable at b=8 of a frame -> frame completes, its sample is stored and strobed, then IDLE. Re-enable -> first frame is discarded again.
- Assert reset_n=0 at b=10 -> adc_cs_n=1 and sclk=1 in the same cycle, bank cleared, no strobe. After release with enable=1, the sweep restarts at ch0 with a discard.
- NUM_CH=3 build -> strobes cycle 0,1,2,0,…; sweep_done on ch2; rd_addr=5 -> rd_data=0.
